// File: rtl/prog_pattern_gen_if.sv
// rtl/prog_pattern_gen_if.sv - instruction-word stream between pattern generator and program loader
//   out_valid : word available (generator -> loader)
//   out_ready : loader accepts (loader -> generator)
//   out_addr  : program address of the word
//   out_word  : packed instruction, NLANES byte lanes, one lane per ROM chip

interface prog_pattern_gen_if #(
    parameter int ADDR_W = 16,
    parameter int NLANES = 6
);
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_W-1:0]     out_addr;
    logic [NLANES*8-1:0]   out_word;

    modport master (output out_valid, output out_addr, output out_word, input out_ready);
    modport slave  (input out_valid, input out_addr, input out_word, output out_ready);
endinterface

// File: rtl/prog_pattern_gen.sv
// rtl/prog_pattern_gen.sv - streaming generator of the device-enumeration test program
//   clk, reset : clock, synchronous active-high reset
//   start      : begin a run (honoured only in IDLE or DONE)
//   imm_mode   : immediate source latched at start, 0 = LFSR, 1 = (addr+10) mod 256
//   out_if     : master side of the word stream (valid/ready/addr/word)
//   busy       : run in progress (preamble or sweep)
//   done       : sticky run-complete
//   lane_sum   : per-lane modulo-256 byte sums, present only with PATGEN_LANE_CHECKSUM_EN

module prog_pattern_gen #(
    parameter int NLANES       = 6,
    parameter int ADDR_W       = 16,
    parameter int DEPTH        = 65536,
    parameter int TDEV_W       = 5,
    parameter int ADEV_W       = 3,
    parameter int BDEV_W       = 4,
    parameter int ALUOP_W      = 5,
    parameter int NTDEV        = 16,
    parameter int NADEV        = 8,
    parameter int NBDEV        = 8,
    parameter int PRE_N        = 7,
    parameter logic [((PRE_N > 0) ? PRE_N : 1)*TDEV_W-1:0] PRE_TARGS =
        {5'd13, 5'd12, 5'd8, 5'd3, 5'd2, 5'd1, 5'd0},
    parameter int TDEV_RAM     = 4,
    parameter int TDEV_HALT    = 7,
    parameter int TDEV_PCHITMP = 8,
    parameter int TDEV_PCLO    = 9,
    parameter int ADEV_UNUSED  = 7,
    parameter int BDEV_RAM     = 4,
    parameter int ALUOP_B      = 1,
    parameter int ALUOP_APLUSB = 4,
    parameter logic [7:0] SEED = 8'h5A
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                imm_mode,
    prog_pattern_gen_if.master  out_if,
    output logic                busy,
    output logic                done
`ifdef PATGEN_LANE_CHECKSUM_EN
    ,
    output logic [NLANES*8-1:0] lane_sum
`endif
);

    localparam int WORD_W    = NLANES * 8;
    localparam int ADDR_LSB  = 8;
    localparam int AMODE_BIT = ADDR_LSB + ADDR_W;
    localparam int CMODE_BIT = AMODE_BIT + 1;
    localparam int SETF_BIT  = AMODE_BIT + 2;
    localparam int COND_LSB  = AMODE_BIT + 3;
    localparam int BDEV_LSB  = COND_LSB + 4;
    localparam int ADEV_LSB  = BDEV_LSB + BDEV_W;
    localparam int TARG_LSB  = ADEV_LSB + ADEV_W;
    localparam int ALUOP_LSB = TARG_LSB + TDEV_W;
    localparam int USED_W    = ALUOP_LSB + ALUOP_W;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_N - 1);
    localparam logic [ADDR_W:0]   PRE_N_X   = (ADDR_W+1)'(PRE_N);

    generate
        if (USED_W > WORD_W) begin : g_width_err
            $error("prog_pattern_gen: packed instruction fields exceed NLANES*8");
        end
        if (DEPTH < 1 || (ADDR_W < 31 && DEPTH > (1 << ADDR_W))) begin : g_depth_err
            $error("prog_pattern_gen: DEPTH must be in 1..2**ADDR_W");
        end
        if (SEED == 8'h00) begin : g_seed_err
            $error("prog_pattern_gen: SEED must be non-zero");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_SWEEP, S_DONE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [WORD_W-1:0]   word_q;
    logic                valid_q;
    logic [7:0]          lfsr;
    logic                mode;

    logic [ADDR_W-1:0]   addr_nx;
    logic [7:0]          lfsr_nx;
    logic                accept;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    // Instruction for address a; preamble vs sweep is decided by the address itself.
    function automatic logic [WORD_W-1:0] build_word(input logic [ADDR_W-1:0] a,
                                                     input logic [7:0] lfsr_v,
                                                     input logic md);
        logic [WORD_W-1:0]  w;
        logic [TDEV_W-1:0]  t;
        logic [ADEV_W-1:0]  ad;
        logic [BDEV_W-1:0]  b;
        logic [ALUOP_W-1:0] op;
        logic [7:0]         imm;
        w = '0;
        if ({1'b0, a} < PRE_N_X) begin
            t   = PRE_TARGS[a*TDEV_W +: TDEV_W];
            ad  = '0;
            b   = '0;
            op  = ALUOP_W'(ALUOP_B);
            imm = 8'h00;
        end else begin
            t  = TDEV_W'(a % NTDEV);
            ad = ADEV_W'(a % NADEV);
            b  = BDEV_W'(a % NBDEV);
            // Skip rules are applied one after another, not as alternatives.
            if (t == TDEV_W'(TDEV_HALT)) t = '0;
            if (t == TDEV_W'(TDEV_PCLO)) t = TDEV_W'(TDEV_PCHITMP);
            if (ad == ADEV_W'(ADEV_UNUSED)) ad = '0;
            if (b == BDEV_W'(BDEV_RAM) && t == TDEV_W'(TDEV_RAM)) b = '0;
            op  = ALUOP_W'(ALUOP_APLUSB);
            imm = md ? 8'(a + 8'd10) : lfsr_v;
        end
        w[7:0]                    = imm;
        w[ADDR_LSB +: ADDR_W]     = a;
        w[AMODE_BIT]              = 1'b0;
        w[CMODE_BIT]              = 1'b0;
        w[SETF_BIT]               = 1'b1;
        w[COND_LSB +: 4]          = 4'h0;
        w[BDEV_LSB +: BDEV_W]     = b;
        w[ADEV_LSB +: ADEV_W]     = ad;
        w[TARG_LSB +: TDEV_W]     = t;
        w[ALUOP_LSB +: ALUOP_W]   = op;
        return w;
    endfunction

    assign accept  = valid_q & out_if.out_ready;
    assign addr_nx = addr + 1'b1;
    // The LFSR only moves past a word that was consumed in the sweep.
    assign lfsr_nx = (state == S_SWEEP) ? lfsr_step(lfsr) : lfsr;

    assign out_if.out_valid = valid_q;
    assign out_if.out_addr  = addr;
    assign out_if.out_word  = word_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            addr    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            lfsr    <= SEED;
            mode    <= 1'b0;
`ifdef PATGEN_LANE_CHECKSUM_EN
            lane_sum <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= (PRE_N == 0) ? S_SWEEP : S_PRE;
                        addr    <= '0;
                        word_q  <= build_word('0, SEED, imm_mode);
                        valid_q <= 1'b1;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        lfsr    <= SEED;
                        mode    <= imm_mode;
`ifdef PATGEN_LANE_CHECKSUM_EN
                        lane_sum <= '0;
`endif
                    end
                end
                S_PRE, S_SWEEP: begin
                    if (accept) begin
`ifdef PATGEN_LANE_CHECKSUM_EN
                        for (int i = 0; i < NLANES; i++) begin
                            lane_sum[i*8 +: 8] <= lane_sum[i*8 +: 8] + word_q[i*8 +: 8];
                        end
`endif
                        // Last-address compare ends the run; addr itself never wraps.
                        if (addr == LAST_ADDR) begin
                            state   <= S_DONE;
                            valid_q <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            addr   <= addr_nx;
                            lfsr   <= lfsr_nx;
                            word_q <= build_word(addr_nx, lfsr_nx, mode);
                            if (state == S_PRE && addr == PRE_LAST) begin
                                state <= S_SWEEP;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_pattern_gen.sv
// tb/tb_prog_pattern_gen.sv - self-checking bench for prog_pattern_gen

module tb_prog_pattern_gen;

    localparam int NI = 3;
    localparam int DEPTH_A = 300;
    localparam int DEPTH_B = 40;
    localparam int DEPTH_C = 8;
    localparam int PRE_T [7] = '{0, 1, 2, 3, 8, 12, 13};

    logic clk = 1'b0;
    logic reset;
    logic start_v [NI];
    logic mode_v  [NI];
    logic rdy_v   [NI];
    logic busy_v  [NI];
    logic done_v  [NI];
    logic        obs_valid [NI];
    logic [15:0] obs_addr  [NI];
    logic [47:0] obs_word  [NI];
`ifdef PATGEN_LANE_CHECKSUM_EN
    logic [47:0] lane_sum_c;
`endif

    int n_vec  = 0;
    int n_fail = 0;
    int lfsr_at [0:DEPTH_A-1];
    logic [47:0] cap [0:DEPTH_A-1];

    always #5 clk = ~clk;

    prog_pattern_gen_if #(.ADDR_W(16), .NLANES(6)) bus_a ();
    prog_pattern_gen_if #(.ADDR_W(16), .NLANES(6)) bus_b ();
    prog_pattern_gen_if #(.ADDR_W(16), .NLANES(6)) bus_c ();

    prog_pattern_gen #(.DEPTH(DEPTH_A)) dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .imm_mode(mode_v[0]),
        .out_if(bus_a.master), .busy(busy_v[0]), .done(done_v[0]));
    prog_pattern_gen #(.DEPTH(DEPTH_B)) dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .imm_mode(mode_v[1]),
        .out_if(bus_b.master), .busy(busy_v[1]), .done(done_v[1]));
    prog_pattern_gen #(.DEPTH(DEPTH_C)) dut_c (
        .clk(clk), .reset(reset), .start(start_v[2]), .imm_mode(mode_v[2]),
        .out_if(bus_c.master),
`ifdef PATGEN_LANE_CHECKSUM_EN
        .lane_sum(lane_sum_c),
`endif
        .busy(busy_v[2]), .done(done_v[2]));

    assign bus_a.out_ready = rdy_v[0];
    assign bus_b.out_ready = rdy_v[1];
    assign bus_c.out_ready = rdy_v[2];
    assign obs_valid[0] = bus_a.out_valid;
    assign obs_valid[1] = bus_b.out_valid;
    assign obs_valid[2] = bus_c.out_valid;
    assign obs_addr[0]  = bus_a.out_addr;
    assign obs_addr[1]  = bus_b.out_addr;
    assign obs_addr[2]  = bus_c.out_addr;
    assign obs_word[0]  = bus_a.out_word;
    assign obs_word[1]  = bus_b.out_word;
    assign obs_word[2]  = bus_c.out_word;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference instruction for address a, straight from the program's definition.
    function automatic logic [47:0] model_word(input int a, input bit md);
        int t, ad, b, op, imm;
        if (a < 7) begin
            t = PRE_T[a]; ad = 0; b = 0; op = 1; imm = 0;
        end else begin
            t = a % 16; ad = a % 8; b = a % 8;
            if (t == 7) t = 0;
            if (t == 9) t = 8;
            if (ad == 7) ad = 0;
            if (b == 4 && t == 4) b = 0;
            op = 4;
            imm = md ? (a + 10) % 256 : lfsr_at[a];
        end
        return {op[4:0], t[4:0], ad[2:0], b[3:0], 4'd0, 1'b1, 1'b0, 1'b0, a[15:0], imm[7:0]};
    endfunction

    // Runs one stream on instance sel; starts at a negedge and ends at a negedge.
    task automatic run_stream(input int sel, input int depth, input bit md,
                              input int stall_pct, input int poke_at, input int abort_at);
        int exp_addr = 0;
        int cycles = 0;
        bit held = 0;
        bit rdy;
        logic [15:0] pa = '0;
        logic [47:0] pw = '0;
        mode_v[sel] = md;
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        mode_v[sel] = ~md;
        check("valid_after_start", obs_valid[sel], 1);
        while (exp_addr < depth && cycles < depth * 20 + 100) begin
            if (exp_addr == abort_at) begin
                reset = 1'b1;
                rdy_v[sel] = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                check("abort_valid", obs_valid[sel], 0);
                check("abort_busy", busy_v[sel], 0);
                check("abort_done", done_v[sel], 0);
                check("abort_addr", obs_addr[sel], 0);
                check("abort_word", obs_word[sel], 0);
                @(negedge clk);
                check("idle_valid", obs_valid[sel], 0);
                return;
            end
            if (held) begin
                check("hold_valid", obs_valid[sel], 1);
                check("hold_addr", obs_addr[sel], pa);
                check("hold_word", obs_word[sel], pw);
            end
            if (stall_pct == 0) check("zero_bubble", obs_valid[sel], 1);
            if (obs_valid[sel]) begin
                check("addr", obs_addr[sel], exp_addr);
                check("word", obs_word[sel], model_word(exp_addr, md));
                check("busy", busy_v[sel], 1);
            end
            rdy = ($urandom_range(99) >= stall_pct);
            rdy_v[sel] = rdy;
            start_v[sel] = (cycles == poke_at);
            held = obs_valid[sel] && !rdy;
            pa = obs_addr[sel];
            pw = obs_word[sel];
            if (obs_valid[sel] && rdy) begin
                if (exp_addr < DEPTH_A) cap[exp_addr] = obs_word[sel];
                exp_addr++;
            end
            cycles++;
            @(negedge clk);
        end
        start_v[sel] = 1'b0;
        rdy_v[sel] = 1'b0;
        check("accept_count", exp_addr, depth);
        check("done_after_last", done_v[sel], 1);
        check("valid_after_last", obs_valid[sel], 0);
        check("busy_after_last", busy_v[sel], 0);
    endtask

    initial begin
        logic [7:0] v;
        logic [47:0] w;
        logic [47:0] exp_sum;

        v = 8'h5A;
        for (int a = 0; a < DEPTH_A; a++) begin
            lfsr_at[a] = 0;
            if (a >= 7) begin
                lfsr_at[a] = int'(v);
                v = (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
            end
        end

        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 1'b0; mode_v[i] = 1'b0; rdy_v[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("rst_valid", obs_valid[i], 0);
            check("rst_busy", busy_v[i], 0);
            check("rst_done", done_v[i], 0);
            check("rst_addr", obs_addr[i], 0);
            check("rst_word", obs_word[i], 0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Mid-run reset at addr 12, then a clean LFSR run from scratch.
        run_stream(0, DEPTH_A, 1'b0, 0, -1, 12);
        run_stream(0, DEPTH_A, 1'b0, 0, -1, -1);
        for (int k = 0; k < 7; k++) begin
            w = cap[k];
            check("pre_targ", w[42:38], PRE_T[k]);
            check("pre_aluop", w[47:43], 1);
            check("pre_immed", w[7:0], 0);
        end
        w = cap[23];
        check("a23_targ", w[42:38], 0);
        check("a23_adev", w[37:35], 0);
        check("a23_bdev", w[34:31], 7);
        w = cap[25];
        check("a25_targ", w[42:38], 8);
        check("a25_adev", w[37:35], 1);
        check("a25_bdev", w[34:31], 1);
        w = cap[20];
        check("a20_targ", w[42:38], 4);
        check("a20_adev", w[37:35], 4);
        check("a20_bdev", w[34:31], 0);
        w = cap[7];
        check("lfsr_a7", w[7:0], 8'h5A);
        check("sweep_aluop", w[47:43], 4);
        w = cap[8];
        check("lfsr_a8", w[7:0], 8'h2D);

        // Address-derived immediates.
        run_stream(0, DEPTH_A, 1'b1, 0, -1, -1);
        w = cap[7];
        check("addr_imm_a7", w[7:0], 17);
        w = cap[250];
        check("addr_imm_a250", w[7:0], 4);

        // Random stalls, start poked mid-run.
        run_stream(1, DEPTH_B, 1'b0, 40, 15, -1);

        // Short run, checksum and restart.
        run_stream(2, DEPTH_C, 1'b1, 0, -1, -1);
        exp_sum = '0;
        for (int a = 0; a < DEPTH_C; a++) begin
            w = model_word(a, 1'b1);
            for (int l = 0; l < 6; l++) exp_sum[l*8 +: 8] = exp_sum[l*8 +: 8] + w[l*8 +: 8];
        end
`ifdef PATGEN_LANE_CHECKSUM_EN
        check("lane_sum", lane_sum_c, exp_sum);
`endif
        mode_v[2] = 1'b1;
        start_v[2] = 1'b1;
        rdy_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        check("restart_valid", obs_valid[2], 1);
        check("restart_addr", obs_addr[2], 0);
        check("restart_done_clr", done_v[2], 0);
`ifdef PATGEN_LANE_CHECKSUM_EN
        check("lane_sum_clear", lane_sum_c, 0);
`endif
        repeat (DEPTH_C + 4) @(negedge clk);
        check("restart_done", done_v[2], 1);
        check("restart_last_addr", obs_addr[2], DEPTH_C - 1);
`ifdef PATGEN_LANE_CHECKSUM_EN
        check("lane_sum_rerun", lane_sum_c, exp_sum);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
